// File: rtl/dmem_initiator.sv
// Load/store initiator between the MEM pipeline stage and a word-addressed data
// memory with registered reads; sub-word stores are done as read-modify-write.
module dmem_initiator #(
  parameter int DEPTH_LOG2 = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] Addr,
  output logic [31:0] Wdata,
  input  logic [31:0] Rdata
);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    CAP,
    WR
  } state_t;

  state_t state, next_state;

  logic [DEPTH_LOG2-1:0] word_idx;
  logic [1:0]            lane;
  logic [1:0]            size;
  logic                  is_store;
  logic                  is_signed;
  logic [31:0]           store_data;
  logic [31:0]           wbuf;
  logic                  accept;
  logic                  req_bad;

  // Pull the addressed byte/half out of a memory word and extend it to 32 bits.
  function automatic logic [31:0] extract_lane(input logic [31:0] word,
                                               input logic [1:0]  sz,
                                               input logic [1:0]  ln,
                                               input logic        sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] result;
    case (ln)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = ln[1] ? word[31:16] : word[15:0];
    case (sz)
      2'b00:   result = sgn ? {{24{b[7]}}, b} : {24'd0, b};
      2'b01:   result = sgn ? {{16{h[15]}}, h} : {16'd0, h};
      default: result = word;
    endcase
    return result;
  endfunction

  function automatic logic [31:0] merge_lanes(input logic [31:0] word,
                                              input logic [31:0] data,
                                              input logic [1:0]  sz,
                                              input logic [1:0]  ln);
    logic [31:0] result;
    result = word;
    case (sz)
      2'b00: begin
        case (ln)
          2'd0:    result[7:0]   = data[7:0];
          2'd1:    result[15:8]  = data[7:0];
          2'd2:    result[23:16] = data[7:0];
          default: result[31:24] = data[7:0];
        endcase
      end
      2'b01: begin
        if (ln[1]) result[31:16] = data[15:0];
        else       result[15:0]  = data[15:0];
      end
      default: result = data;
    endcase
    return result;
  endfunction

  // Illegal size, misalignment or an address beyond the memory depth.
  always_comb begin
    req_bad = 1'b0;
    case (req_size)
      2'b00:   req_bad = 1'b0;
      2'b01:   req_bad = req_addr[0];
      2'b10:   req_bad = |req_addr[1:0];
      default: req_bad = 1'b1;
    endcase
    if (|req_addr[31:DEPTH_LOG2+2]) req_bad = 1'b1;
  end

  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept = 1'b1;
          if (!req_bad) next_state = (req_we && req_size == 2'b10) ? WR : RD;
        end
      end
      RD:      next_state = CAP;
      CAP:     next_state = is_store ? WR : IDLE;
      WR:      next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Strobes are gated by rst so an abort can never commit a partial write.
  always_comb begin
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    Addr     = 32'd0;
    Wdata    = 32'd0;
    if (state != IDLE) Addr = {{(32-DEPTH_LOG2){1'b0}}, word_idx};
    if (state == RD) MemRead = !rst;
    if (state == WR) begin
      MemWrite = !rst;
      Wdata    = wbuf;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'd0;
      word_idx   <= '0;
      lane       <= 2'd0;
      size       <= 2'd0;
      is_store   <= 1'b0;
      is_signed  <= 1'b0;
      store_data <= 32'd0;
      wbuf       <= 32'd0;
    end else begin
      state      <= next_state;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (req_bad) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'd0;
            end else begin
              word_idx   <= req_addr[DEPTH_LOG2+1:2];
              lane       <= req_addr[1:0];
              size       <= req_size;
              is_store   <= req_we;
              is_signed  <= req_signed;
              store_data <= req_wdata;
              wbuf       <= req_wdata;
            end
          end
        end
        CAP: begin
          // Rdata now holds the word captured by the memory on the RD edge.
          if (is_store) begin
            wbuf <= merge_lanes(Rdata, store_data, size, lane);
          end else begin
            resp_valid <= 1'b1;
            resp_rdata <= extract_lane(Rdata, size, lane, is_signed);
          end
        end
        WR: begin
          resp_valid <= 1'b1;
          resp_rdata <= 32'd0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_initiator.sv
// Bench for dmem_initiator: registered-read memory model plus a byte-level
// reference of memory contents, directed cases followed by random traffic.
module tb_dmem_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] Wdata;
  logic [31:0] Rdata;

  logic [31:0] mem [32];
  logic [31:0] ref_mem [32];
  int          rd_count = 0;
  int          wr_count = 0;
  logic [31:0] rd_addr;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        pre_en;
  logic [4:0]  pre_idx;
  logic [31:0] pre_data;
  int          total = 0;
  int          bad = 0;

  dmem_initiator #(.DEPTH_LOG2(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_rdata (resp_rdata),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .Addr       (Addr),
    .Wdata      (Wdata),
    .Rdata      (Rdata)
  );

  always #5 clk = ~clk;

  // Data memory: registered read, write on the strobe edge, access bookkeeping.
  always @(posedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_data;
    if (MemWrite) begin
      mem[Addr[4:0]] <= Wdata;
      wr_count       <= wr_count + 1;
      wr_addr        <= Addr;
      wr_data        <= Wdata;
    end
    if (MemRead) begin
      Rdata    <= mem[Addr[4:0]];
      rd_count <= rd_count + 1;
      rd_addr  <= Addr;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic model_err(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'b11) || (sz == 2'b01 && a[0]) ||
           (sz == 2'b10 && a[1:0] != 2'b00) || (a >= 32'd128);
  endfunction

  task automatic scrambleInputs();
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_size   = 2'($urandom);
    req_signed = 1'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
  endtask

  // Entered and left on a negedge; one complete transaction with checks.
  task automatic applyStimulus(input logic we, input logic [1:0] sz, input logic sgn,
                               input logic [31:0] addr, input logic [31:0] wdata);
    logic        err;
    logic [4:0]  idx;
    logic [31:0] exp_rdata;
    logic [31:0] exp_word;
    logic [31:0] v;
    logic [31:0] mask;
    int          nb;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
    int          rd0;
    int          wr0;
    int          lat;
    err       = model_err(sz, addr);
    idx       = addr[6:2];
    nb        = 1 << sz;
    exp_rdata = 32'd0;
    exp_word  = ref_mem[idx];
    mask      = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
    if (!err && !we) begin
      v = (ref_mem[idx] >> (8 * addr[1:0])) & mask;
      if (sgn && nb < 4 && v[8*nb-1]) v = v | ~mask;
      exp_rdata = v;
    end
    if (!err && we) begin
      for (int i = 0; i < nb; i++) exp_word[8*(addr[1:0]+i) +: 8] = wdata[8*i +: 8];
    end
    exp_lat = err ? 0 : (we && nb == 4) ? 1 : we ? 3 : 2;
    exp_rd  = (err || (we && nb == 4)) ? 0 : 1;
    exp_wr  = (!err && we) ? 1 : 0;

    req_valid  = 1'b1;
    req_we     = we;
    req_size   = sz;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    rd0 = rd_count;
    wr0 = wr_count;
    checkOutput("ready_idle", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    scrambleInputs();
    if (!err) checkOutput("ready_busy", 32'(req_ready), 32'd0);
    lat = 0;
    while (!resp_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("resp_valid", 32'(resp_valid), 32'd1);
    checkOutput("latency", 32'(lat), 32'(exp_lat));
    checkOutput("resp_err", 32'(resp_err), 32'(err));
    checkOutput("resp_rdata", resp_rdata, exp_rdata);
    checkOutput("mem_reads", 32'(rd_count - rd0), 32'(exp_rd));
    checkOutput("mem_writes", 32'(wr_count - wr0), 32'(exp_wr));
    if (exp_rd == 1) checkOutput("read_addr", rd_addr, 32'(idx));
    if (exp_wr == 1) begin
      checkOutput("write_addr", wr_addr, 32'(idx));
      checkOutput("write_data", wr_data, exp_word);
    end
    ref_mem[idx] = exp_word;
    @(negedge clk);
    checkOutput("resp_pulse", 32'(resp_valid), 32'd0);
  endtask

  // Byte store aborted by rst; abort_at 1 = during CAP, 2 = during WR.
  task automatic abortStore(input logic [31:0] addr, input logic [31:0] wdata, input int abort_at);
    int wr0;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = addr;
    req_wdata  = wdata;
    wr0 = wr_count;
    @(posedge clk);
    @(negedge clk);
    scrambleInputs();
    repeat (abort_at) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("abort_gate", 32'(MemWrite), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_writes", 32'(wr_count - wr0), 32'd0);
    checkOutput("abort_ready", 32'(req_ready), 32'd1);
    checkOutput("abort_resp", 32'(resp_valid), 32'd0);
    checkOutput("abort_rdata", resp_rdata, 32'd0);
    checkOutput("abort_mem", mem[addr[6:2]], ref_mem[addr[6:2]]);
  endtask

  // The same word load held on req_valid is accepted again during the response.
  task automatic backToBack(input logic [31:0] addr);
    logic [31:0] exp;
    int          lat;
    exp        = ref_mem[addr[6:2]];
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_size   = 2'b10;
    req_signed = 1'b0;
    req_addr   = addr;
    req_wdata  = 32'd0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("b2b_busy1", 32'(req_ready), 32'd0);
    lat = 0;
    while (!resp_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("b2b_lat1", 32'(lat), 32'd2);
    checkOutput("b2b_ready_resp", 32'(req_ready), 32'd1);
    checkOutput("b2b_rdata1", resp_rdata, exp);
    @(posedge clk);
    @(negedge clk);
    scrambleInputs();
    checkOutput("b2b_busy2", 32'(req_ready), 32'd0);
    lat = 0;
    while (!resp_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("b2b_lat2", 32'(lat), 32'd2);
    checkOutput("b2b_rdata2", resp_rdata, exp);
    @(negedge clk);
    checkOutput("b2b_pulse", 32'(resp_valid), 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    pre_en     = 1'b1;
    for (int i = 0; i < 32; i++) begin
      pre_idx    = 5'(i);
      pre_data   = (i == 1) ? 32'h8899_AABB : $urandom;
      ref_mem[i] = pre_data;
      @(negedge clk);
    end
    pre_en = 1'b0;

    checkOutput("rst_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst_err", 32'(resp_err), 32'd0);
    checkOutput("rst_rdata", resp_rdata, 32'd0);
    checkOutput("rst_memread", 32'(MemRead), 32'd0);
    checkOutput("rst_memwrite", 32'(MemWrite), 32'd0);
    checkOutput("rst_addr", Addr, 32'd0);
    checkOutput("rst_wdata", Wdata, 32'd0);
    rst = 1'b0;

    applyStimulus(1'b0, 2'b10, 1'b0, 32'h4, 32'd0);
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h7, 32'd0);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h7, 32'd0);
    applyStimulus(1'b0, 2'b01, 1'b1, 32'h6, 32'd0);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h6, 32'd0);
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h3, 32'h1234);
    applyStimulus(1'b0, 2'b11, 1'b0, 32'h0, 32'd0);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h80, 32'd0);
    abortStore(32'h4, 32'h0000_0011, 1);
    abortStore(32'h4, 32'h0000_0022, 2);
    checkOutput("word1_kept", mem[1], 32'h8899_AABB);
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h5, 32'h0000_005A);
    checkOutput("byte_store_word", mem[1], 32'h8899_5ABB);
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h8, 32'hCAFE_F00D);
    backToBack(32'h4);

    for (int n = 0; n < 200; n++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      int          b;
      sz = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 15) == 0) sz = 2'b11;
      a = {25'd0, 5'($urandom), 2'($urandom)};
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
      end
      if ($urandom_range(0, 15) == 0) begin
        b = int'($urandom_range(7, 31));
        a[b] = 1'b1;
      end
      applyStimulus(1'($urandom), sz, 1'($urandom), a, $urandom);
    end

    for (int i = 0; i < 32; i++) checkOutput("final_mem", mem[i], ref_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
